// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution sequencer: FSM states, coordinate width
// and the per-read tag carried alongside each pixel.
package conv_pkg;
  localparam int unsigned COORD_W   = 9;
  localparam int unsigned MIN_WIDTH = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic               v;    // a read was issued
    logic               win;  // that read completes a full in-image window
    logic [COORD_W-1:0] r;    // window centre row
    logic [COORD_W-1:0] c;    // window centre column
  } tag_t;
endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter with a runtime wrap value and a last-position flag.
module raster_counter
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [COORD_W-1:0] wrap,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last_c
);

  assign last_c = (row == wrap) && (col == wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == wrap) begin
        col <= '0;
        row <= (row == wrap) ? '0 : row + COORD_W'(1);
      end else begin
        col <= col + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv3x3_sequencer.sv
// Streams one square plane from pixel RAM into the 3x3 window collector,
// tags each read with its window centre and cross-checks the collector stall.
module conv3x3_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = 256,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned COLL_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] stage_width,
  input  logic               mac_ready,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  pixel_out,
  output logic               pixel_valid,
  input  logic               coll_stall,
  output logic [COORD_W-1:0] coll_width,
  output logic               window_valid,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic               busy,
  output logic               done,
  output logic               sync_err
);

  localparam int unsigned DLY     = 1 + COLL_LAT;
  localparam int unsigned DRAIN_W = $clog2(DLY + 1);

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 busy_d, done_d;
  logic                 start_ok;
  logic [COORD_W-1:0]   wrap, ir, ic;
  logic                 issue_last;
  tag_t                 tag_in;
  tag_t                 pipe_q [DLY];
  logic                 dv;

  assign start_ok = start && (state_q == IDLE) &&
                    (stage_width >= COORD_W'(MIN_WIDTH)) &&
                    (stage_width <= COORD_W'(IMAGE_WIDTH));

  // Read issue follows mac_ready in the same cycle so a drop stops reads at once.
  assign rd_en     = (state_q == RUN) && mac_ready;
  assign wrap      = coll_width - COORD_W'(1);
  assign pixel_out = pixel_valid ? rd_data : '0;

  raster_counter u_issue (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .en     (rd_en),
    .wrap   (wrap),
    .row    (ir),
    .col    (ic),
    .last_c (issue_last)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (start_ok) state_d = RUN;
      RUN: begin
        if (rd_en && issue_last) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DLY - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      coll_width  <= '0;
      rd_addr     <= '0;
      pixel_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      busy        <= busy_d;
      done        <= done_d;
      pixel_valid <= rd_en;
      if (start_ok) coll_width <= stage_width;
      // Incrementing address replaces row*width+col.
      if (start_ok) begin
        rd_addr <= '0;
      end else if (rd_en) begin
        rd_addr <= issue_last ? '0 : rd_addr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.v   = rd_en;
    tag_in.win = rd_en && (ir >= COORD_W'(2)) && (ic >= COORD_W'(2));
    tag_in.r   = ir - COORD_W'(1);
    tag_in.c   = ic - COORD_W'(1);
  end

  // Tag delay line matches the RAM read plus collector latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DLY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < int'(DLY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dv           = pipe_q[DLY-1].v;
  assign window_valid = pipe_q[DLY-1].win;
  assign win_row      = pipe_q[DLY-1].r;
  assign win_col      = pipe_q[DLY-1].c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (start_ok) begin
      sync_err <= 1'b0;
    end else if (dv && (window_valid == coll_stall)) begin
      sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Directed bench for conv3x3_sequencer with a pixel RAM model and a
// behavioural 3x3 collector stall model.
module tb_conv3x3_sequencer;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] stage_width;
  logic       mac_ready;
  logic       rd_en;
  logic [15:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       coll_stall;
  logic [8:0] coll_width;
  logic       window_valid;
  logic [8:0] win_row, win_col;
  logic       busy, done, sync_err;

  logic force_stall0;
  logic cstall;
  int   cr, cc;
  int   n_chk, n_fail;

  conv3x3_sequencer #(.IMAGE_WIDTH(256), .ADDR_W(16), .DATA_W(8), .COLL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage_width(stage_width),
    .mac_ready(mac_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .coll_stall(coll_stall),
    .coll_width(coll_width), .window_valid(window_valid), .win_row(win_row),
    .win_col(win_col), .busy(busy), .done(done), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_f(input int a);
    return 8'(a ^ (a >> 8) ^ 8'hA5);
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= ram_f(int'(rd_addr));

  // Collector: stall drops once the last shifted pixel completes an in-image window.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr <= 0; cc <= 0; cstall <= 1'b1;
    end else if (start && !busy) begin
      cr <= 0; cc <= 0;
    end else if (pixel_valid) begin
      cstall <= !(cr >= 2 && cc >= 2);
      if (cc == int'(coll_width) - 1) begin
        cc <= 0;
        cr <= (cr == int'(coll_width) - 1) ? 0 : cr + 1;
      end else begin
        cc <= cc + 1;
      end
    end
  end

  assign coll_stall = force_stall0 ? 1'b0 : cstall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0] width;
    int pause_at, pause_len, restart_at, force_from, force_to;
    int exp_reads, exp_wins, exp_first_win, exp_done;
    logic exp_sync;
  } vec_t;

  function automatic vec_t mk(input int w, input int pa, input int pl, input int rs,
                              input int ff, input int ft, input int er, input int ew,
                              input int efw, input int ed, input logic es);
    vec_t v;
    v.width = 9'(w); v.pause_at = pa; v.pause_len = pl; v.restart_at = rs;
    v.force_from = ff; v.force_to = ft; v.exp_reads = er; v.exp_wins = ew;
    v.exp_first_win = efw; v.exp_done = ed; v.exp_sync = es;
    return v;
  endfunction

  task automatic run_frame(input vec_t v);
    int cyc, exp_addr, exp_paddr, reads, wins, first_win, done_cyc, pause_left;
    int er, ec, last_r, last_c, w, budget;
    bit fin;
    w = int'(v.width);
    budget = w * w + 40;
    cyc = 0; exp_addr = 0; exp_paddr = 0; reads = 0; wins = 0; first_win = 0;
    done_cyc = 0; pause_left = v.pause_len; er = 1; ec = 1; last_r = 0; last_c = 0;
    fin = 0;
    @(negedge clk);
    stage_width = v.width; start = 1'b1; mac_ready = 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == v.restart_at);
      force_stall0 = (cyc >= v.force_from && cyc < v.force_to);
      mac_ready = !(exp_addr == v.pause_at && pause_left > 0);
      if (!mac_ready) pause_left--;
      #1;
      if (cyc == 1) begin
        chk("sync_err_at_start", 32'(sync_err), 0);
        chk("busy_at_start", 32'(busy), 1);
      end
      if (!mac_ready) chk("rd_en_while_paused", 32'(rd_en), 0);
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
        exp_addr++; reads++;
      end
      if (pixel_valid) begin
        chk("pixel_out", 32'(pixel_out), 32'(ram_f(exp_paddr)));
        exp_paddr++;
      end
      if (window_valid) begin
        if (wins == 0) first_win = cyc;
        chk("win_row", 32'(win_row), 32'(er));
        chk("win_col", 32'(win_col), 32'(ec));
        last_r = int'(win_row); last_c = int'(win_col);
        ec++;
        if (ec > w - 2) begin ec = 1; er++; end
        wins++;
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1;
        chk("busy_at_done", 32'(busy), 0);
      end
    end
    start = 1'b0; force_stall0 = 1'b0; mac_ready = 1'b1;
    chk("done_seen_in_budget", 32'(fin), 1);
    chk("read_count", 32'(reads), 32'(v.exp_reads));
    chk("window_count", 32'(wins), 32'(v.exp_wins));
    chk("first_window_cycle", 32'(first_win), 32'(v.exp_first_win));
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    chk("last_win_row", 32'(last_r), 32'(w - 2));
    chk("last_win_col", 32'(last_c), 32'(w - 2));
    chk("sync_err_end", 32'(sync_err), 32'(v.exp_sync));
    @(negedge clk); #1;
    chk("done_single_pulse", 32'(done), 0);
  endtask

  task automatic illegal_start(input int w);
    bit saw;
    saw = 0;
    @(negedge clk);
    stage_width = 9'(w); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rd_en || busy) saw = 1;
      @(negedge clk);
    end
    chk("illegal_width_ignored", 32'(saw), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_pixel_out"}, 32'(pixel_out), 0);
    chk({tag, "_window_valid"}, 32'(window_valid), 0);
    chk({tag, "_win_row"}, 32'(win_row), 0);
    chk({tag, "_win_col"}, 32'(win_col), 0);
    chk({tag, "_coll_width"}, 32'(coll_width), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sync_err"}, 32'(sync_err), 0);
  endtask

  vec_t vecs[5];

  initial begin
    bit found, saw_done;
    n_chk = 0; n_fail = 0;
    // width, pause_at, pause_len, restart_at, force_from, force_to,
    // reads, windows, first window cycle, done cycle, final sync_err
    vecs[0] = mk(8,  -1, 0, 0,  0, 0, 64,  36,  21, 67,  1'b0);
    vecs[1] = mk(3,  -1, 0, 0,  0, 0, 9,   1,   11, 12,  1'b0);
    vecs[2] = mk(8,  30, 5, 0,  0, 0, 64,  36,  21, 72,  1'b0);
    vecs[3] = mk(5,  -1, 0, 10, 0, 0, 25,  9,   15, 28,  1'b0);
    vecs[4] = mk(16, -1, 0, 0,  0, 0, 256, 196, 37, 259, 1'b0);

    rst_n = 1'b0; start = 1'b0; stage_width = '0; mac_ready = 1'b1; force_stall0 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    illegal_start(2);
    illegal_start(300);

    // Forced stall low while the (0,0) tag emerges: sticky error, cleared by next start.
    run_frame(mk(8, -1, 0, 0, 2, 5, 64, 36, 21, 67, 1'b1));
    run_frame(vecs[0]);

    // Reset in the middle of a frame at pixel 40.
    found = 0;
    @(negedge clk);
    stage_width = 9'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      #1;
      if (rd_en && rd_addr == 16'd40) found = 1;
      else @(negedge clk);
    end
    chk("reset_point_reached", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("no_done_after_abort", 32'(saw_done), 0);
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
